mem_sequencer: RTL and testbench



---
 rtl/mem_sequencer_pkg.sv | 40 ++++
 rtl/mem_sequencer_load_extend.sv | 22 ++
 rtl/mem_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared encodings and helpers for the byte-serial memory sequencer.
package mem_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WRITE   = 3'd2,
    IO_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] WIDTH_B      = 2'b00;
  localparam logic [1:0] WIDTH_H      = 2'b01;
  localparam logic [1:0] WIDTH_W      = 2'b10;
  localparam int         UNSIGNED_BIT = 2;

  // The UART and other IO devices live where addr[17:16] == 2'b11.
  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

  // Index of the final byte of an access of the given size.
  function automatic logic [2:0] last_idx(input logic [1:0] size);
    case (size)
      WIDTH_B: return 3'd0;
      WIDTH_H: return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [2:0] idx);
    case (idx[1:0])
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_sequencer_load_extend.sv
// Sign- or zero-extends a reassembled load word according to the access width.
module mem_sequencer_load_extend
  import mem_sequencer_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  width,
  output logic [31:0] data
);

  logic is_unsigned;
  assign is_unsigned = width[UNSIGNED_BIT];

  always_comb begin
    data = raw;
    case (width[1:0])
      WIDTH_B: data = is_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      WIDTH_H: data = is_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_sequencer.sv
// Arbitrates fetch and load/store ports onto the 8-bit RAM/IO bus, one byte per cycle,
// reassembling read data and stalling IO writes while the UART FIFO is full.
module mem_sequencer
  import mem_sequencer_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [2:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  dout_reg, dout_next;
  logic        wr_reg, wr_next;
  logic        if_done_reg, if_done_next;
  logic        ls_done_reg, ls_done_next;
  logic [31:0] if_data_reg, if_data_next;
  logic [31:0] ls_rdata_reg, ls_rdata_next;
  logic [31:0] raw_reg, raw_next;
  logic        fetch_reg, fetch_next;
  logic [2:0]  width_reg, width_next;
  logic [31:0] base_reg, base_next;
  logic [31:0] wdata_reg, wdata_next;

  logic [31:0] raw_cap;
  logic [31:0] ext_data;
  logic [2:0]  cnt_inc;
  logic        last_byte;

  assign cnt_inc   = cnt_reg + 3'd1;
  assign last_byte = (cnt_reg == last_idx(width_reg[1:0]));

  // Incoming byte lands in lane cnt; other lanes keep what was already captured.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cap
      assign raw_cap[8*gi +: 8] = (cnt_reg == 3'(gi)) ? mem_din : raw_reg[8*gi +: 8];
    end
  endgenerate

  mem_sequencer_load_extend u_load_extend (
    .raw   (raw_cap),
    .width (width_reg),
    .data  (ext_data)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mem_a_next    = mem_a_reg;
    dout_next     = dout_reg;
    wr_next       = wr_reg;
    if_done_next  = 1'b0;
    ls_done_next  = 1'b0;
    if_data_next  = if_data_reg;
    ls_rdata_next = ls_rdata_reg;
    raw_next      = raw_reg;
    fetch_next    = fetch_reg;
    width_next    = width_reg;
    base_next     = base_reg;
    wdata_next    = wdata_reg;

    case (state_reg)
      IDLE: begin
        wr_next = 1'b0;
        if (ls_req) begin
          fetch_next = 1'b0;
          width_next = ls_width;
          base_next  = ls_addr;
          wdata_next = ls_wdata;
          mem_a_next = ls_addr;
          cnt_next   = 3'd0;
          raw_next   = '0;
          if (ls_wr) begin
            dout_next = ls_wdata[7:0];
            if (is_io(ls_addr) && io_buffer_full) begin
              state_next = IO_WAIT;
            end else begin
              wr_next    = 1'b1;
              state_next = WRITE;
            end
          end else begin
            state_next = READ;
          end
        end else if (if_req && !if_flush) begin
          fetch_next = 1'b1;
          width_next = {1'b0, WIDTH_W};
          base_next  = if_addr;
          mem_a_next = if_addr;
          cnt_next   = 3'd0;
          raw_next   = '0;
          state_next = READ;
        end
      end

      READ: begin
        if (fetch_reg && if_flush) begin
          // Flush beats a simultaneous capture; the partial word is dropped.
          cnt_next   = 3'd0;
          state_next = IDLE;
        end else begin
          raw_next   = raw_cap;
          mem_a_next = base_reg + {29'b0, cnt_inc};
          if (last_byte) begin
            cnt_next = 3'd0;
            if (fetch_reg) begin
              if_data_next = raw_cap;
              if_done_next = 1'b1;
            end else begin
              ls_rdata_next = ext_data;
              ls_done_next  = 1'b1;
            end
            state_next = DONE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end

      WRITE: begin
        if (last_byte) begin
          wr_next      = 1'b0;
          cnt_next     = 3'd0;
          ls_done_next = 1'b1;
          state_next   = DONE;
        end else begin
          cnt_next   = cnt_inc;
          mem_a_next = base_reg + {29'b0, cnt_inc};
          dout_next  = byte_of(wdata_reg, cnt_inc);
          if (is_io(base_reg + {29'b0, cnt_inc}) && io_buffer_full) begin
            wr_next    = 1'b0;
            state_next = IO_WAIT;
          end else begin
            wr_next = 1'b1;
          end
        end
      end

      IO_WAIT: begin
        wr_next = 1'b0;
        if (!io_buffer_full) begin
          wr_next    = 1'b1;
          state_next = WRITE;
        end
      end

      DONE: begin
        wr_next    = 1'b0;
        state_next = IDLE;
      end

      default: begin
        wr_next    = 1'b0;
        cnt_next   = 3'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      mem_a_reg    <= '0;
      dout_reg     <= '0;
      wr_reg       <= 1'b0;
      if_done_reg  <= 1'b0;
      ls_done_reg  <= 1'b0;
      if_data_reg  <= '0;
      ls_rdata_reg <= '0;
      raw_reg      <= '0;
      fetch_reg    <= 1'b0;
      width_reg    <= '0;
      base_reg     <= '0;
      wdata_reg    <= '0;
    end else if (rdy_in) begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mem_a_reg    <= mem_a_next;
      dout_reg     <= dout_next;
      wr_reg       <= wr_next;
      if_done_reg  <= if_done_next;
      ls_done_reg  <= ls_done_next;
      if_data_reg  <= if_data_next;
      ls_rdata_reg <= ls_rdata_next;
      raw_reg      <= raw_next;
      fetch_reg    <= fetch_next;
      width_reg    <= width_next;
      base_reg     <= base_next;
      wdata_reg    <= wdata_next;
    end
  end

  // Gated combinationally so a stalled cycle can never commit an IO byte twice.
  assign mem_wr   = wr_reg & rdy_in;
  assign mem_a    = mem_a_reg;
  assign mem_dout = dout_reg;
  assign if_done  = if_done_reg;
  assign ls_done  = ls_done_reg;
  assign if_data  = if_data_reg;
  assign ls_rdata = ls_rdata_reg;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: a byte RAM model, a write log and a result scoreboard.
module tb_mem_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [2:0]  ls_width;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  mem_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_width(ls_width), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [0:4095];
  assign mem_din = ram[mem_a[11:0]];

  typedef struct {
    bit          fetch;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] wa_log[$];
  logic [7:0]  wd_log[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input bit fetch, input bit chk_data, input logic [31:0] data);
    exp_t e;
    e.fetch = fetch; e.chk_data = chk_data; e.data = data;
    sb.push_back(e);
  endtask

  // What the bus commits at the coming edge, sampled mid-cycle with this cycle's inputs.
  task automatic commit();
    if (mem_wr) begin
      wa_log.push_back(mem_a);
      wd_log.push_back(mem_dout);
      if (mem_a[17:16] != 2'b11) ram[mem_a[11:0]] = mem_dout;
    end
  endtask

  task automatic observe();
    exp_t e;
    if (if_done || ls_done) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done observed=if%0b/ls%0b expected=no_done", if_done, ls_done);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_port", {30'b0, if_done, ls_done}, e.fetch ? 32'd2 : 32'd1);
        if (e.chk_data) chk(e.fetch ? "if_data" : "ls_rdata", e.fetch ? if_data : ls_rdata, e.data);
        $display("txn %s done if_data=0x%08h ls_rdata=0x%08h t=%0t",
                 e.fetch ? "fetch" : "ls", if_data, ls_rdata, $time);
      end
    end
  endtask

  task automatic tick();
    #1;
    commit();
    @(posedge clk_in);
    @(negedge clk_in);
    observe();
  endtask

  task automatic wait_done(input int limit, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < limit) begin
      tick();
      lat++;
      seen = if_done || ls_done;
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic ls_issue(input bit wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    ls_req = 1'b1; ls_wr = wr; ls_width = w; ls_addr = a; ls_wdata = d;
  endtask

  int          lat;
  logic [31:0] a_hold;
  logic [31:0] word;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h040] = 8'h80;
    ram[12'h042] = 8'h34; ram[12'h043] = 8'h92;
    ram[12'h080] = 8'hA5;
    ram[12'h300] = 8'h01; ram[12'h301] = 8'h02; ram[12'h302] = 8'h03; ram[12'h303] = 8'h04;

    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_width = '0; ls_addr = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    chk("rst_done", {30'b0, if_done, ls_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;
    tick();

    // Word fetch: address steps once per cycle, done four cycles after accept.
    push_exp(1'b1, 1'b1, 32'h44332211);
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_mem_a", mem_a, 32'h100 + 32'(k));
      chk("fetch_not_done_yet", {31'b0, if_done}, 32'd0);
    end
    tick();
    chk("fetch_done_4cyc", {31'b0, if_done}, 32'd1);
    if_req = 1'b0;
    tick();
    chk("fetch_done_pulse", {31'b0, if_done}, 32'd0);

    // Byte and half loads, signed and unsigned.
    push_exp(1'b0, 1'b1, 32'hFFFFFF80);
    ls_issue(1'b0, 3'b000, 32'h40, 32'h0);
    wait_done(10, lat);
    ls_req = 1'b0;
    chk("lb_latency", 32'(lat), 32'd2);
    tick();
    push_exp(1'b0, 1'b1, 32'h00000080);
    ls_issue(1'b0, 3'b100, 32'h40, 32'h0);
    wait_done(10, lat);
    ls_req = 1'b0;
    tick();
    push_exp(1'b0, 1'b1, 32'hFFFF9234);
    ls_issue(1'b0, 3'b001, 32'h42, 32'h0);
    wait_done(10, lat);
    ls_req = 1'b0;
    tick();
    push_exp(1'b0, 1'b1, 32'h00009234);
    ls_issue(1'b0, 3'b101, 32'h42, 32'h0);
    wait_done(10, lat);
    ls_req = 1'b0;
    tick();

    // Word store to RAM: four consecutive byte writes, LSB first.
    wa_log.delete(); wd_log.delete();
    push_exp(1'b0, 1'b0, 32'h0);
    ls_issue(1'b1, 3'b010, 32'h200, 32'hDEADBEEF);
    wait_done(12, lat);
    ls_req = 1'b0;
    chk("sw_latency", 32'(lat), 32'd5);
    chk("sw_write_count", 32'(wa_log.size()), 32'd4);
    word = 32'hDEADBEEF;
    for (int k = 0; k < 4 && k < wa_log.size(); k++) begin
      chk("sw_addr", wa_log[k], 32'h200 + 32'(k));
      chk("sw_byte", {24'b0, wd_log[k]}, {24'b0, word[8*k +: 8]});
    end
    tick();

    // UART byte store held off while the FIFO reports full.
    wa_log.delete(); wd_log.delete();
    io_buffer_full = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0);
    ls_issue(1'b1, 3'b000, 32'h30000, 32'h41);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_stall_wr", {31'b0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    wait_done(10, lat);
    ls_req = 1'b0;
    chk("io_write_count", 32'(wa_log.size()), 32'd1);
    if (wa_log.size() != 0) begin
      chk("io_addr", wa_log[0], 32'h30000);
      chk("io_byte", {24'b0, wd_log[0]}, 32'h41);
    end
    tick();

    // Both ports request together: load first, fetch accepted only after DONE.
    push_exp(1'b0, 1'b1, 32'h000000A5);
    push_exp(1'b1, 1'b1, 32'h04030201);
    ls_issue(1'b0, 3'b100, 32'h80, 32'h0);
    if_req = 1'b1; if_addr = 32'h300;
    wait_done(10, lat);
    ls_req = 1'b0;
    chk("arb_ls_first", {30'b0, if_done, ls_done}, 32'd1);
    wait_done(12, lat);
    if_req = 1'b0;
    chk("arb_fetch_latency", 32'(lat), 32'd6);
    tick();

    // Flush after one captured byte: back to IDLE with no fetch completion.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    chk("flush_no_done", {31'b0, if_done}, 32'd0);
    if_flush = 1'b0;
    push_exp(1'b0, 1'b1, 32'hFFFFFF80);
    ls_issue(1'b0, 3'b000, 32'h40, 32'h0);
    wait_done(10, lat);
    ls_req = 1'b0;
    chk("flush_then_idle", 32'(lat), 32'd2);
    tick();

    // Two-cycle rdy stall in the middle of a word store.
    wa_log.delete(); wd_log.delete();
    push_exp(1'b0, 1'b0, 32'h0);
    ls_issue(1'b1, 3'b010, 32'h210, 32'hCAFEF00D);
    tick();
    tick();
    rdy_in = 1'b0;
    a_hold = mem_a;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_wr", {31'b0, mem_wr}, 32'd0);
      chk("stall_mem_a", mem_a, a_hold);
    end
    rdy_in = 1'b1;
    wait_done(10, lat);
    ls_req = 1'b0;
    chk("stall_write_count", 32'(wa_log.size()), 32'd4);
    word = 32'hCAFEF00D;
    for (int k = 0; k < 4 && k < wa_log.size(); k++) begin
      chk("stall_addr", wa_log[k], 32'h210 + 32'(k));
      chk("stall_byte", {24'b0, wd_log[k]}, {24'b0, word[8*k +: 8]});
    end
    tick();

    // Reset in the middle of a fetch aborts it silently.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    rst_in = 1'b1; if_req = 1'b0;
    #1;
    chk("midrst_mem_a", mem_a, 32'h0);
    chk("midrst_ls_rdata", ls_rdata, 32'h0);
    chk("midrst_if_data", if_data, 32'h0);
    tick();
    rst_in = 1'b0;
    repeat (6) tick();
    chk("midrst_no_done", {30'b0, if_done, ls_done}, 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
